// File: rtl/mask_gen_pipe.sv
// mask_gen_pipe: 3-stage weighted colour-difference mask generator with valid/ready and per-frame match count.
// Build option MASK_HYST_EN adds threshold_lo and row hysteresis on the mask decision.
module mask_gen_pipe #(
    parameter int RW     = 5,
    parameter int GW     = 6,
    parameter int BW     = 5,
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int WW     = 4,
    parameter int LAST_X = 639,
    parameter int LAST_Y = 479
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic [31:0]       threshold,
`ifdef MASK_HYST_EN
    input  logic [31:0]       threshold_lo,
`endif
    input  logic [WW-1:0]     w_r,
    input  logic [WW-1:0]     w_g,
    input  logic [WW-1:0]     w_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XW-1:0]     sync_x,
    input  logic [YW-1:0]     sync_y,
    input  logic [RW-1:0]     ccd_r,
    input  logic [GW-1:0]     ccd_g,
    input  logic [BW-1:0]     ccd_b,
    input  logic [RW-1:0]     dvi_r,
    input  logic [GW-1:0]     dvi_g,
    input  logic [BW-1:0]     dvi_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mask,
    output logic [XW-1:0]     mask_x,
    output logic [YW-1:0]     mask_y,
    output logic              frame_done,
    output logic [XW+YW-1:0]  mask_count
);
    localparam int M  = (RW > GW) ? ((RW > BW) ? RW : BW) : ((GW > BW) ? GW : BW);
    localparam int TW = 2 * M + WW;
    localparam int SW = TW + 2;
    localparam int CW = XW + YW;

    function automatic logic [M-1:0] adiff(input logic [M-1:0] a, input logic [M-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    logic          en, xfer, last, mask_d;
    logic          v1_q, v2_q, ov_q, mask_q, fd_q;
    logic [M-1:0]  dr_d, dg_d, db_d, dr_q, dg_q, db_q;
    logic [TW-1:0] tr_d, tg_d, tb_d, tr_q, tg_q, tb_q;
    logic [XW-1:0] x1_q, x2_q, mx_q;
    logic [YW-1:0] y1_q, y2_q, my_q;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt_d, cnt_q, mc_q;

    // The whole pipe advances together, so a stall can neither drop nor duplicate a pixel.
    assign en       = ~ov_q | out_ready;
    assign in_ready = en;

    always_comb begin
        dr_d = adiff(M'(ccd_r) << (M - RW), M'(dvi_r) << (M - RW));
        dg_d = adiff(M'(ccd_g) << (M - GW), M'(dvi_g) << (M - GW));
        db_d = adiff(M'(ccd_b) << (M - BW), M'(dvi_b) << (M - BW));
        tr_d = TW'(dr_q) * TW'(dr_q) * TW'(w_r);
        tg_d = TW'(dg_q) * TW'(dg_q) * TW'(w_g);
        tb_d = TW'(db_q) * TW'(db_q) * TW'(w_b);
        sum  = SW'(tr_q) + SW'(tg_q) + SW'(tb_q);
    end

`ifdef MASK_HYST_EN
    logic hyst_q, prev_m;
    // With en high a valid output register is leaving now, so it is the previous pixel.
    assign prev_m = ov_q ? mask_q : hyst_q;
    assign mask_d = (x2_q == '0 || prev_m) ? (32'(sum) <= threshold) : (32'(sum) <= threshold_lo);

    always_ff @(posedge clk_25 or negedge rst_n)
        if (!rst_n)
            hyst_q <= 1'b1;
        else if (xfer)
            hyst_q <= mask_q;
`else
    assign mask_d = 32'(sum) <= threshold;
`endif

    always_ff @(posedge clk_25 or negedge rst_n)
        if (!rst_n) begin
            {v1_q, v2_q, ov_q} <= '0;
            {dr_q, dg_q, db_q} <= '0;
            {tr_q, tg_q, tb_q} <= '0;
            {x1_q, y1_q, x2_q, y2_q} <= '0;
            mask_q <= 1'b1;
            mx_q   <= '0;
            my_q   <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            dr_q <= dr_d;
            dg_q <= dg_d;
            db_q <= db_d;
            x1_q <= sync_x;
            y1_q <= sync_y;
            v2_q <= v1_q;
            tr_q <= tr_d;
            tg_q <= tg_d;
            tb_q <= tb_d;
            x2_q <= x1_q;
            y2_q <= y1_q;
            ov_q <= v2_q;
            if (v2_q) begin
                mask_q <= mask_d;
                mx_q   <= x2_q;
                my_q   <= y2_q;
            end
        end

    assign xfer  = ov_q & out_ready;
    assign last  = xfer && mx_q == XW'(LAST_X) && my_q == YW'(LAST_Y);
    assign cnt_d = (mask_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // The last pixel of a frame is counted into the latched total before the running count clears.
    always_ff @(posedge clk_25 or negedge rst_n)
        if (!rst_n) begin
            cnt_q <= '0;
            mc_q  <= '0;
            fd_q  <= 1'b0;
        end else begin
            fd_q <= last;
            if (xfer)
                cnt_q <= last ? '0 : cnt_d;
            if (last)
                mc_q <= cnt_d;
        end

    assign out_valid  = ov_q;
    assign mask       = mask_q;
    assign mask_x     = mx_q;
    assign mask_y     = my_q;
    assign frame_done = fd_q;
    assign mask_count = mc_q;
endmodule

// File: tb/tb_mask_gen_pipe.sv
// tb_mask_gen_pipe: randomized and directed stimulus checked against a queue-based reference model of mask_gen_pipe.
// Uses a 4x2 frame so frame statistics are exercised often; MASK_HYST_EN enables the hysteresis checks.
module tb_mask_gen_pipe;
    localparam int RW = 5, GW = 6, BW = 5, XW = 10, YW = 10, WW = 4, LX = 3, LY = 1, M = 6;
    localparam int FP = (LX + 1) * (LY + 1);

    logic              clk_25 = 1'b0, rst_n = 1'b0;
    logic [31:0]       threshold = '0, threshold_lo = '0;
    logic [WW-1:0]     w_r = 1, w_g = 1, w_b = 1;
    logic              in_valid = 1'b0, out_ready = 1'b1;
    logic              in_ready, out_valid, mask, frame_done;
    logic [XW-1:0]     sync_x = '0, mask_x;
    logic [YW-1:0]     sync_y = '0, mask_y;
    logic [RW-1:0]     ccd_r = '0, dvi_r = '0;
    logic [GW-1:0]     ccd_g = '0, dvi_g = '0;
    logic [BW-1:0]     ccd_b = '0, dvi_b = '0;
    logic [XW+YW-1:0]  mask_count;

    mask_gen_pipe #(.LAST_X(LX), .LAST_Y(LY)) dut (
        .clk_25(clk_25), .rst_n(rst_n), .threshold(threshold),
`ifdef MASK_HYST_EN
        .threshold_lo(threshold_lo),
`endif
        .w_r(w_r), .w_g(w_g), .w_b(w_b), .in_valid(in_valid), .in_ready(in_ready),
        .sync_x(sync_x), .sync_y(sync_y), .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
        .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b), .out_valid(out_valid), .out_ready(out_ready),
        .mask(mask), .mask_x(mask_x), .mask_y(mask_y), .frame_done(frame_done), .mask_count(mask_count)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct { longint sum; int x; int y; int cyc; } ent_t;
    ent_t q[$];
    ent_t e;
    int errs = 0, checks = 0, cyc = 0, run = 0, exp_mc = 0, last_m = -1, pidx = 0, stall = 0;
    bit prev_m = 1, fd_pend = 0, hold = 0, lat_chk = 0, rnd_ready = 0, em;
    logic hm;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;

    always @(posedge clk_25) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint absl(input longint v);
        return v < 0 ? -v : v;
    endfunction

    // Weighted squared difference after scaling every channel up to M bits.
    function automatic longint sumf(input int cr, cg, cb, dr, dg, db, wr, wg, wb);
        longint a, b, c;
        a = absl(longint'(cr << (M - RW)) - longint'(dr << (M - RW)));
        b = absl(longint'(cg << (M - GW)) - longint'(dg << (M - GW)));
        c = absl(longint'(cb << (M - BW)) - longint'(db << (M - BW)));
        return a * a * wr + b * b * wg + c * c * wb;
    endfunction

    always @(negedge clk_25) if (rst_n) begin
        chk("in_ready", in_ready, !out_valid || out_ready);
        chk("frame_done", frame_done, fd_pend);
        if (fd_pend) chk("mask_count", mask_count, exp_mc);
        fd_pend = 0;
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_mask", mask, hm);
            chk("hold_x", mask_x, hx);
            chk("hold_y", mask_y, hy);
        end
        hold = out_valid && !out_ready;
        hm = mask; hx = mask_x; hy = mask_y;
        if (in_valid && in_ready) begin
            e.sum = sumf(ccd_r, ccd_g, ccd_b, dvi_r, dvi_g, dvi_b, w_r, w_g, w_b);
            e.x = sync_x; e.y = sync_y; e.cyc = cyc;
            q.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errs++;
                $display("FAIL spurious_output: got x=%0d y=%0d required no output", mask_x, mask_y);
            end else begin
                e = q.pop_front();
`ifdef MASK_HYST_EN
                em = (e.x == 0 || prev_m) ? (e.sum <= threshold) : (e.sum <= threshold_lo);
`else
                em = e.sum <= threshold;
`endif
                chk("mask", mask, em);
                chk("mask_x", mask_x, e.x);
                chk("mask_y", mask_y, e.y);
                if (lat_chk) chk("latency", cyc - e.cyc, 3);
                prev_m = em;
                if (em && run != (1 << (XW + YW)) - 1) run++;
                if (e.x == LX && e.y == LY) begin
                    exp_mc = run; run = 0; fd_pend = 1;
                end
                last_m = mask;
            end
        end
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic set_ready();
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send(input int cr, cg, cb, dr, dg, db);
        bit acc = 0;
        in_valid = 1'b1;
        sync_x = XW'(pidx % (LX + 1));
        sync_y = YW'((pidx / (LX + 1)) % (LY + 1));
        ccd_r = RW'(cr); ccd_g = GW'(cg); ccd_b = BW'(cb);
        dvi_r = RW'(dr); dvi_g = GW'(dg); dvi_b = BW'(db);
        for (int k = 0; k < 100 && !acc; k++) begin
            set_ready();
            @(negedge clk_25);
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles required 1");
            $fatal(1, "accept timeout");
        end
        in_valid = 1'b0;
        pidx++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            set_ready();
            tick();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) idle(1);
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic align();
        while (pidx % FP != 0) send(5, 5, 5, 5, 5, 5);
    endtask

    task automatic send_rand();
        int cr, cg, cb;
        cr = $urandom_range(0, 31); cg = $urandom_range(0, 63); cb = $urandom_range(0, 31);
        send(cr, cg, cb, (cr + $urandom_range(0, 4)) % 32, (cg + $urandom_range(0, 4)) % 64,
             (cb + $urandom_range(0, 4)) % 32);
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_25);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mask", mask, 1);
        chk("rst_mask_x", mask_x, 0);
        chk("rst_mask_y", mask_y, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_mask_count", mask_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk_25); #1 rst_n = 1'b1;

        chk("model_r31", sumf(31, 0, 0, 0, 0, 0, 1, 1, 1), 3844);
        chk("model_w15", sumf(31, 0, 0, 0, 0, 0, 15, 1, 1), 57660);
        chk("model_w0", sumf(31, 0, 0, 0, 0, 0, 0, 1, 1), 0);

        // Identical pixels, continuous stream: every output matches, 3-cycle latency.
        lat_chk = 1;
        for (int i = 0; i < FP; i++) begin
            int r = $urandom_range(0, 31), g = $urandom_range(0, 63), b = $urandom_range(0, 31);
            send(r, g, b, r, g, b);
        end
        drain();
        lat_chk = 0;
        chk("frame1_count", mask_count, FP);

        // Red-only difference around the threshold boundary, then weight extremes.
        threshold = 3843; send(31, 7, 9, 0, 7, 9); drain(); chk("r31_thr3843", last_m, 0);
        threshold = 3844; send(31, 7, 9, 0, 7, 9); drain(); chk("r31_thr3844", last_m, 1);
        threshold = 0; w_r = 0; send(31, 7, 9, 0, 7, 9); drain(); chk("r31_wr0", last_m, 1);
        w_r = 15; threshold = 57659; send(31, 7, 9, 0, 7, 9); drain(); chk("r31_wr15_lo", last_m, 0);
        threshold = 57660; send(31, 7, 9, 0, 7, 9); drain(); chk("r31_wr15_eq", last_m, 1);
        w_r = 1; threshold = 0;
        align();

        // Backpressure: out_ready low for 5 cycles mid-stream.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) stall = 5;
            send_rand();
        end
        drain();
        align();

        // Frame statistics: 5 of 8 match, then 2 of 8 in the next frame.
        for (int i = 0; i < FP; i++)
            if (i inside {0, 2, 3, 5, 7}) send(4, 4, 4, 4, 4, 4); else send(31, 4, 4, 0, 4, 4);
        drain();
        chk("frame_count5", mask_count, 5);
        for (int i = 0; i < FP; i++)
            if (i inside {1, 6}) send(4, 4, 4, 4, 4, 4); else send(31, 4, 4, 0, 4, 4);
        drain();
        chk("frame_count2", mask_count, 2);

        // Randomized traffic with random backpressure, bubbles, weights and thresholds.
        rnd_ready = 1;
        for (int blk = 0; blk < 4; blk++) begin
            drain();
            w_r = WW'($urandom_range(0, 15)); w_g = WW'($urandom_range(0, 15)); w_b = WW'($urandom_range(0, 15));
            threshold = $urandom_range(0, 400);
            threshold_lo = $urandom_range(0, threshold);
            for (int i = 0; i < 16; i++) begin
                send_rand();
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        rnd_ready = 0;
        w_r = 1; w_g = 1; w_b = 1; threshold = 0; threshold_lo = 0;

        // Reset with three pixels in flight.
        send(1, 1, 1, 1, 1, 1); send(2, 2, 2, 2, 2, 2); send(3, 3, 3, 3, 3, 3);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mask", mask, 1);
        chk("midrst_mask_count", mask_count, 0);
        chk("midrst_frame_done", frame_done, 0);
        q.delete(); run = 0; prev_m = 1; fd_pend = 0; hold = 0; pidx = 0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < FP; i++)
            if (i inside {0, 5}) send(31, 4, 4, 0, 4, 4); else send(6, 6, 6, 6, 6, 6);
        drain();
        chk("post_rst_count", mask_count, 6);

`ifdef MASK_HYST_EN
        // Row sums 9, 5, 1, 9 with thresholds 8 / 4.
        threshold = 8; threshold_lo = 4;
        send(0, 3, 0, 0, 0, 0); drain(); chk("hyst_x0", last_m, 0);
        send(1, 1, 0, 0, 0, 0); drain(); chk("hyst_x1", last_m, 0);
        send(0, 1, 0, 0, 0, 0); drain(); chk("hyst_x2", last_m, 1);
        send(0, 3, 0, 0, 0, 0); drain(); chk("hyst_x3", last_m, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
